// File: rtl/maindec_seq.sv
// rtl/maindec_seq.sv - MIPS main decoder with read-modify-write sequencing for SB/SH
// Combinational decode for most instructions; a small FSM stretches SB/SH into read, merge and write.
module maindec_seq #(
    parameter int MEM_LAT    = 1,
    parameter int ENABLE_RMW = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       instr_valid,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic [4:0] dest,
    output logic       regwrite,
    output logic       regdst2,
    output logic       regdst1,
    output logic       alusrc,
    output logic       branch,
    output logic       data_read,
    output logic       data_write,
    output logic       memtoreg1,
    output logic       jump1,
    output logic       jump,
    output logic [1:0] aluop,
    output logic [2:0] loadcontrol,
    output logic [1:0] storecontrol,
    output logic       rmw_merge,
    output logic       storeloop,
    output logic       stall,
    output logic       illegal
);

    typedef enum logic [1:0] {IDLE, READ, MERGE, WRITE} state_t;

    localparam logic [11:0] CTL_RTYPE  = 12'b101000000010;
    localparam logic [11:0] CTL_MTHILO = 12'b000000000010;
    localparam logic [11:0] CTL_JR     = 12'b000010001101;
    localparam logic [11:0] CTL_JALR   = 12'b110010001101;
    localparam logic [11:0] CTL_LOAD   = 12'b100101010000;
    localparam logic [11:0] CTL_ITYPE  = 12'b100100000010;
    localparam logic [11:0] CTL_BRANCH = 12'b000010000010;
    localparam logic [11:0] CTL_BRLINK = 12'b110010000010;
    localparam logic [11:0] CTL_J      = 12'b000010000101;
    localparam logic [11:0] CTL_JAL    = 12'b110010000101;
    localparam logic [11:0] CTL_SW     = 12'b000100100000;
    localparam logic [11:0] CTL_RMW_RD = 12'b000101000000;
    localparam logic [11:0] CTL_MERGE  = 12'b000000000010;

    localparam logic [5:0] OP_SB = 6'b101000;
    localparam logic [5:0] OP_SH = 6'b101001;

    localparam logic [1:0] LAT_M1 = 2'(MEM_LAT - 1);

    state_t      state, state_next;
    logic [1:0]  cnt, cnt_next;
    logic [1:0]  size_q, size_next;

    logic [11:0] dec_ctl;
    logic [2:0]  dec_lc;
    logic [1:0]  dec_sc;
    logic        dec_il;
    logic        is_sub;

    logic [11:0] ctl;

    assign {regwrite, regdst2, regdst1, alusrc, branch, data_read,
            data_write, memtoreg1, jump1, jump, aluop} = ctl;

    always_comb begin
        dec_ctl = '0;
        dec_lc  = '0;
        dec_sc  = '0;
        dec_il  = 1'b0;
        is_sub  = 1'b0;
        case (op)
            6'b000000: begin
                case (funct)
                    6'b010001, 6'b010011: dec_ctl = CTL_MTHILO;
                    6'b001000:            dec_ctl = CTL_JR;
                    6'b001001:            dec_ctl = CTL_JALR;
                    default:              dec_ctl = CTL_RTYPE;
                endcase
            end
            6'b000001: begin
                case (dest)
                    5'b00000, 5'b00001: dec_ctl = CTL_BRANCH;
                    5'b10000, 5'b10001: dec_ctl = CTL_BRLINK;
                    default:            dec_il  = 1'b1;
                endcase
            end
            6'b000010: dec_ctl = CTL_J;
            6'b000011: dec_ctl = CTL_JAL;
            6'b000100, 6'b000101, 6'b000110, 6'b000111: dec_ctl = CTL_BRANCH;
            6'b001001, 6'b001010, 6'b001011, 6'b001100,
            6'b001101, 6'b001110, 6'b001111: dec_ctl = CTL_ITYPE;
            6'b100000: begin dec_ctl = CTL_LOAD; dec_lc = 3'b000; end
            6'b100100: begin dec_ctl = CTL_LOAD; dec_lc = 3'b001; end
            6'b100001: begin dec_ctl = CTL_LOAD; dec_lc = 3'b010; end
            6'b100101: begin dec_ctl = CTL_LOAD; dec_lc = 3'b011; end
            6'b100011: begin dec_ctl = CTL_LOAD; dec_lc = 3'b101; end
            6'b100010: begin dec_ctl = CTL_LOAD; dec_lc = 3'b110; end
            6'b100110: begin dec_ctl = CTL_LOAD; dec_lc = 3'b111; end
            OP_SB: begin dec_ctl = CTL_SW; dec_sc = 2'b10; is_sub = 1'b1; end
            OP_SH: begin dec_ctl = CTL_SW; dec_sc = 2'b01; is_sub = 1'b1; end
            6'b101011: dec_ctl = CTL_SW;
            default: dec_il = 1'b1;
        endcase
    end

    always_comb begin
        ctl          = '0;
        loadcontrol  = '0;
        storecontrol = '0;
        rmw_merge    = 1'b0;
        storeloop    = 1'b0;
        stall        = 1'b0;
        illegal      = 1'b0;
        state_next   = state;
        cnt_next     = cnt;
        size_next    = size_q;
        case (state)
            IDLE: begin
                if (instr_valid) begin
                    if ((ENABLE_RMW != 0) && is_sub) begin
                        ctl        = CTL_RMW_RD;
                        stall      = 1'b1;
                        storeloop  = 1'b1;
                        size_next  = dec_sc;
                        cnt_next   = LAT_M1;
                        state_next = (MEM_LAT == 1) ? MERGE : READ;
                    end else begin
                        ctl          = dec_ctl;
                        loadcontrol  = dec_lc;
                        storecontrol = dec_sc;
                        illegal      = dec_il;
                    end
                end
            end
            READ: begin
                ctl       = CTL_RMW_RD;
                stall     = 1'b1;
                storeloop = 1'b1;
                cnt_next  = cnt - 2'd1;
                // The decremented count reaching zero closes the read window.
                if (cnt == 2'd1) state_next = MERGE;
            end
            MERGE: begin
                ctl        = CTL_MERGE;
                rmw_merge  = 1'b1;
                stall      = 1'b1;
                storeloop  = 1'b1;
                state_next = WRITE;
            end
            WRITE: begin
                ctl          = CTL_SW;
                storecontrol = size_q;
                storeloop    = 1'b1;
                state_next   = IDLE;
            end
            default: state_next = IDLE;
        endcase
        if (reset) begin
            ctl          = '0;
            loadcontrol  = '0;
            storecontrol = '0;
            rmw_merge    = 1'b0;
            storeloop    = 1'b0;
            stall        = 1'b0;
            illegal      = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            cnt    <= '0;
            size_q <= '0;
        end else begin
            state  <= state_next;
            cnt    <= cnt_next;
            size_q <= size_next;
        end
    end

endmodule

// File: tb/tb_maindec_seq.sv
// tb/tb_maindec_seq.sv - scoreboard bench for maindec_seq at three parameter points
// DUT0: MEM_LAT=1 RMW on; DUT1: MEM_LAT=3 RMW on; DUT2: MEM_LAT=1 RMW off.
module tb_maindec_seq;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       instr_valid = 1'b0;
    logic [5:0] op = '0;
    logic [5:0] funct = '0;
    logic [4:0] dest = '0;

    wire [20:0] o [3];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        maindec_seq #(
            .MEM_LAT    ((g == 1) ? 3 : 1),
            .ENABLE_RMW ((g == 2) ? 0 : 1)
        ) dut (
            .clk          (clk),
            .reset        (reset),
            .instr_valid  (instr_valid),
            .op           (op),
            .funct        (funct),
            .dest         (dest),
            .regwrite     (o[g][20]),
            .regdst2      (o[g][19]),
            .regdst1      (o[g][18]),
            .alusrc       (o[g][17]),
            .branch       (o[g][16]),
            .data_read    (o[g][15]),
            .data_write   (o[g][14]),
            .memtoreg1    (o[g][13]),
            .jump1        (o[g][12]),
            .jump         (o[g][11]),
            .aluop        (o[g][10:9]),
            .loadcontrol  (o[g][8:6]),
            .storecontrol (o[g][5:4]),
            .rmw_merge    (o[g][3]),
            .storeloop    (o[g][2]),
            .stall        (o[g][1]),
            .illegal      (o[g][0])
        );
    end

    typedef struct {
        string            name;
        logic [2:0][20:0] e;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;

    // Packs {bundle, loadcontrol, storecontrol, rmw_merge, storeloop, stall, illegal}.
    function automatic logic [20:0] mk(logic [11:0] b, logic [2:0] lc, logic [1:0] sc, logic [3:0] f);
        return {b, lc, sc, f};
    endfunction

    logic [20:0] Z, RT, MTHI, JR, JALR, ORI, LUI, BEQ, BAL, BGEZ, J, JAL, SW, SB1, SH1, ILL;
    logic [20:0] LB, LBU, LH, LHU, LW, LWL, LWR, ISS, MRG, WB, WH;

    initial begin
        Z    = '0;
        RT   = mk(12'b101000000010, 3'b000, 2'b00, 4'b0000);
        MTHI = mk(12'b000000000010, 3'b000, 2'b00, 4'b0000);
        JR   = mk(12'b000010001101, 3'b000, 2'b00, 4'b0000);
        JALR = mk(12'b110010001101, 3'b000, 2'b00, 4'b0000);
        ORI  = mk(12'b100100000010, 3'b000, 2'b00, 4'b0000);
        LUI  = ORI;
        BEQ  = mk(12'b000010000010, 3'b000, 2'b00, 4'b0000);
        BGEZ = BEQ;
        BAL  = mk(12'b110010000010, 3'b000, 2'b00, 4'b0000);
        J    = mk(12'b000010000101, 3'b000, 2'b00, 4'b0000);
        JAL  = mk(12'b110010000101, 3'b000, 2'b00, 4'b0000);
        SW   = mk(12'b000100100000, 3'b000, 2'b00, 4'b0000);
        SB1  = mk(12'b000100100000, 3'b000, 2'b10, 4'b0000);
        SH1  = mk(12'b000100100000, 3'b000, 2'b01, 4'b0000);
        ILL  = mk(12'b000000000000, 3'b000, 2'b00, 4'b0001);
        LB   = mk(12'b100101010000, 3'b000, 2'b00, 4'b0000);
        LBU  = mk(12'b100101010000, 3'b001, 2'b00, 4'b0000);
        LH   = mk(12'b100101010000, 3'b010, 2'b00, 4'b0000);
        LHU  = mk(12'b100101010000, 3'b011, 2'b00, 4'b0000);
        LW   = mk(12'b100101010000, 3'b101, 2'b00, 4'b0000);
        LWL  = mk(12'b100101010000, 3'b110, 2'b00, 4'b0000);
        LWR  = mk(12'b100101010000, 3'b111, 2'b00, 4'b0000);
        ISS  = mk(12'b000101000000, 3'b000, 2'b00, 4'b0110);
        MRG  = mk(12'b000000000010, 3'b000, 2'b00, 4'b1110);
        WB   = mk(12'b000100100000, 3'b000, 2'b10, 4'b0100);
        WH   = mk(12'b000100100000, 3'b000, 2'b01, 4'b0100);
    end

    task automatic step(input string name, input logic rst, input logic v, input logic [5:0] opc,
                        input logic [5:0] fn, input logic [4:0] d,
                        input logic [20:0] e0, input logic [20:0] e1, input logic [20:0] e2);
        exp_t x;
        @(posedge clk);
        #1;
        reset       = rst;
        instr_valid = v;
        op          = opc;
        funct       = fn;
        dest        = d;
        x.name = name;
        x.e    = {e2, e1, e0};
        sb.push_back(x);
    endtask

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t x;
            x = sb.pop_front();
            for (int k = 0; k < 3; k++) begin
                tests++;
                if (o[k] !== x.e[k]) begin
                    fails++;
                    $display("FAIL %s dut%0d got %b expected %b", x.name, k, o[k], x.e[k]);
                end
            end
        end
    end

    initial begin
        step("reset0", 1, 1, 6'b000000, 6'b100001, 5'd0, Z, Z, Z);
        step("reset1", 1, 1, 6'b101000, 6'b000000, 5'd0, Z, Z, Z);
        step("invalid", 0, 0, 6'b000000, 6'b100001, 5'd0, Z, Z, Z);
        step("addu", 0, 1, 6'b000000, 6'b100001, 5'd0, RT, RT, RT);
        step("mthi", 0, 1, 6'b000000, 6'b010001, 5'd0, MTHI, MTHI, MTHI);
        step("mtlo", 0, 1, 6'b000000, 6'b010011, 5'd0, MTHI, MTHI, MTHI);
        step("jr", 0, 1, 6'b000000, 6'b001000, 5'd0, JR, JR, JR);
        step("jalr", 0, 1, 6'b000000, 6'b001001, 5'd0, JALR, JALR, JALR);
        step("ori", 0, 1, 6'b001101, 6'b0, 5'd0, ORI, ORI, ORI);
        step("lui", 0, 1, 6'b001111, 6'b0, 5'd0, LUI, LUI, LUI);
        step("beq", 0, 1, 6'b000100, 6'b0, 5'd0, BEQ, BEQ, BEQ);
        step("j", 0, 1, 6'b000010, 6'b0, 5'd0, J, J, J);
        step("jal", 0, 1, 6'b000011, 6'b0, 5'd0, JAL, JAL, JAL);
        step("lb", 0, 1, 6'b100000, 6'b0, 5'd0, LB, LB, LB);
        step("lbu", 0, 1, 6'b100100, 6'b0, 5'd0, LBU, LBU, LBU);
        step("lh", 0, 1, 6'b100001, 6'b0, 5'd0, LH, LH, LH);
        step("lhu", 0, 1, 6'b100101, 6'b0, 5'd0, LHU, LHU, LHU);
        step("lw", 0, 1, 6'b100011, 6'b0, 5'd0, LW, LW, LW);
        step("lwl", 0, 1, 6'b100010, 6'b0, 5'd0, LWL, LWL, LWL);
        step("lwr", 0, 1, 6'b100110, 6'b0, 5'd0, LWR, LWR, LWR);
        step("sw", 0, 1, 6'b101011, 6'b0, 5'd0, SW, SW, SW);
        step("bgezal", 0, 1, 6'b000001, 6'b0, 5'b10001, BAL, BAL, BAL);
        step("bgez", 0, 1, 6'b000001, 6'b0, 5'b00001, BGEZ, BGEZ, BGEZ);
        step("regimm_bad", 0, 1, 6'b000001, 6'b0, 5'b00011, ILL, ILL, ILL);
        step("op_3f", 0, 1, 6'b111111, 6'b0, 5'd0, ILL, ILL, ILL);
        step("addi", 0, 1, 6'b001000, 6'b0, 5'd0, ILL, ILL, ILL);

        // SB then idle bus
        step("sb_t0", 0, 1, 6'b101000, 6'b0, 5'd0, ISS, ISS, SB1);
        step("sb_t1", 0, 0, 6'b101000, 6'b0, 5'd0, MRG, ISS, Z);
        step("sb_t2", 0, 0, 6'b101000, 6'b0, 5'd0, WB, ISS, Z);
        step("sb_t3", 0, 0, 6'b101000, 6'b0, 5'd0, Z, MRG, Z);
        step("sb_t4", 0, 0, 6'b101000, 6'b0, 5'd0, Z, WB, Z);
        step("sb_t5", 0, 0, 6'b101000, 6'b0, 5'd0, Z, Z, Z);

        // SH immediately followed by LW held on the bus
        step("sh_t0", 0, 1, 6'b101001, 6'b0, 5'd0, ISS, ISS, SH1);
        step("sh_t1", 0, 1, 6'b100011, 6'b0, 5'd0, MRG, ISS, LW);
        step("sh_t2", 0, 1, 6'b100011, 6'b0, 5'd0, WH, ISS, LW);
        step("sh_t3", 0, 1, 6'b100011, 6'b0, 5'd0, LW, MRG, LW);
        step("sh_t4", 0, 1, 6'b100011, 6'b0, 5'd0, LW, WH, LW);
        step("sh_t5", 0, 1, 6'b100011, 6'b0, 5'd0, LW, LW, LW);

        // Back-to-back SB held continuously
        step("b2b_t0", 0, 1, 6'b101000, 6'b0, 5'd0, ISS, ISS, SB1);
        step("b2b_t1", 0, 1, 6'b101000, 6'b0, 5'd0, MRG, ISS, SB1);
        step("b2b_t2", 0, 1, 6'b101000, 6'b0, 5'd0, WB, ISS, SB1);
        step("b2b_t3", 0, 1, 6'b101000, 6'b0, 5'd0, ISS, MRG, SB1);
        step("b2b_t4", 0, 1, 6'b101000, 6'b0, 5'd0, MRG, WB, SB1);
        step("b2b_t5", 0, 1, 6'b101000, 6'b0, 5'd0, WB, ISS, SB1);
        step("b2b_t6", 0, 0, 6'b101000, 6'b0, 5'd0, Z, ISS, Z);
        step("b2b_t7", 0, 0, 6'b101000, 6'b0, 5'd0, Z, ISS, Z);
        step("b2b_t8", 0, 0, 6'b101000, 6'b0, 5'd0, Z, MRG, Z);
        step("b2b_t9", 0, 0, 6'b101000, 6'b0, 5'd0, Z, WB, Z);
        step("b2b_t10", 0, 0, 6'b101000, 6'b0, 5'd0, Z, Z, Z);

        // Reset in the MERGE cycle aborts the sequence
        step("abort_t0", 0, 1, 6'b101000, 6'b0, 5'd0, ISS, ISS, SB1);
        step("abort_t1", 1, 0, 6'b101000, 6'b0, 5'd0, Z, Z, Z);
        step("abort_t2", 0, 0, 6'b101000, 6'b0, 5'd0, Z, Z, Z);
        step("abort_t3", 0, 0, 6'b101000, 6'b0, 5'd0, Z, Z, Z);
        step("abort_t4", 0, 1, 6'b000000, 6'b100001, 5'd0, RT, RT, RT);

        for (int w = 0; w < 10 && sb.size() > 0; w++) @(negedge clk);
        #1;
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL drain pending=%0d required=0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
